// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the 8x8 LED matrix scan controller.
//   scan_state_e : IDLE / SCAN / BLANK scan sequencer states
//   MTX_ROWS, MTX_SLOTS, MTX_ROW_W : matrix geometry and PWM slot count
//   row_onehot() : row index to one-hot row drive
package matrix_pkg;

  localparam int MTX_ROWS  = 8;
  localparam int MTX_SLOTS = 16;
  localparam int MTX_ROW_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

  function automatic logic [MTX_ROWS-1:0] row_onehot(input logic [MTX_ROW_W-1:0] idx);
    return MTX_ROWS'(1) << idx;
  endfunction

endpackage

// File: rtl/matrix_prescaler.sv
// matrix_prescaler: PWM slot tick generator.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr   : synchronous clear, holds the count at 0
//   count : current position inside the slot, 0..PRESCALE-1
//   tick  : high in the last cycle of a slot (terminal count)
module matrix_prescaler #(
  parameter int PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  output logic [15:0] count,
  output logic        tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) count <= '0;
    else                    count <= count + 16'd1;
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: double-buffered 8x8 LED frame store with a prescaled,
// PWM-dimmed row scan and tear-free front/back swap at frame boundaries.
//   CLK, RST          : clock, synchronous active-high reset
//   EN                : scan enable (0 = dark, sequencer held in IDLE)
//   WR, ADDR, WDATA   : byte write into back[ADDR]
//   BRIGHT            : lit slots per row (0..15), latched at each row start
//   SWAP_REQ/SWAP_ACK : level request / one-cycle swap pulse
//   FRAME             : pulse with the first displayed cycle of row 0
//   row, column       : registered one-hot row drive and column byte
// Optional build macro MATRIX_BLANK_EN inserts BLANK_CYC dark cycles after
// every row (anti-ghosting); without it rows run back-to-back.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int PRESCALE  = 100,
  parameter int BLANK_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       WR,
  input  logic [2:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic [3:0] BRIGHT,
  input  logic       SWAP_REQ,
  output logic       SWAP_ACK,
  output logic       FRAME,
  output logic [7:0] row,
  output logic [7:0] column
);

  scan_state_e          state, state_nxt;
  logic [MTX_ROW_W-1:0] rowidx;
  logic [3:0]           slot;
  logic [3:0]           bright_lat;
  logic                 front;
  logic [7:0]           mem [2][MTX_ROWS];

  logic        clr, tick, row_end, advance, swap, lit;
  logic [15:0] count;

  matrix_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (CLK),
    .rst   (RST),
    .clr   (clr),
    .count (count),
    .tick  (tick)
  );

  // Row end is the terminal count of the last PWM slot.
  assign row_end = (state == SCAN) && tick && (slot == 4'(MTX_SLOTS - 1));
  assign clr     = (state != SCAN) || !EN || row_end;

`ifdef MATRIX_BLANK_EN
  logic [7:0] blank_cnt;
  logic       blank_done;

  assign blank_done = (blank_cnt == 8'(BLANK_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RST || state != BLANK) blank_cnt <= '0;
    else                       blank_cnt <= blank_cnt + 8'd1;
  end

  // The row index steps only once the dark gap has elapsed.
  assign advance = (state == BLANK) && EN && blank_done;
`else
  assign advance = EN && row_end;
`endif

  // Frame boundary: the advance out of row 7. The pointer flips on the same
  // edge, so a write in this cycle still lands in the pre-swap back buffer.
  assign swap     = advance && (rowidx == MTX_ROW_W'(MTX_ROWS - 1)) && SWAP_REQ;
  assign SWAP_ACK = swap;

  assign lit = EN && (state == SCAN) && (slot < bright_lat);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (EN) state_nxt = SCAN;
      SCAN: begin
        if (!EN) state_nxt = IDLE;
`ifdef MATRIX_BLANK_EN
        else if (row_end) state_nxt = BLANK;
`endif
      end
      BLANK: begin
        if (!EN) state_nxt = IDLE;
`ifdef MATRIX_BLANK_EN
        else if (blank_done) state_nxt = SCAN;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rowidx     <= '0;
      slot       <= '0;
      bright_lat <= '0;
      front      <= 1'b0;
      row        <= '0;
      column     <= '0;
      FRAME      <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < MTX_ROWS; r++)
          mem[b][r] <= '0;
    end else begin
      state <= state_nxt;

      if (WR) mem[~front][ADDR] <= WDATA;
      if (swap) front <= ~front;

      // Idle or disabled: restart from row 0, slot 0 on the next enable.
      if (state == IDLE || !EN) begin
        rowidx <= '0;
        slot   <= '0;
        if (EN) bright_lat <= BRIGHT;
      end else begin
        if (state == SCAN && tick) slot <= slot + 4'd1;
        if (advance) begin
          rowidx     <= rowidx + 3'd1;
          bright_lat <= BRIGHT;
        end
      end

      // Output stage: registered view of the current slot.
      row    <= lit ? row_onehot(rowidx) : '0;
      column <= lit ? mem[front][rowidx] : '0;
      FRAME  <= EN && (state == SCAN) && (rowidx == '0) && (slot == '0) && (count == '0);
    end
  end

endmodule
